vec_unpack_5_31: RTL and testbench
==================================

VEC_UNPACK_5_31 -- requirements
Module: vec_unpack_5_31

Interface
REQ-001 SHALL have parameter N_VEC, default 5: number of vectors packed per input word.
REQ-002 SHALL have parameter VEC_W, default 31: width of each vector in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port s_valid, input, 1 bit: packed input word valid.
REQ-006 SHALL have port s_ready, output, 1 bit: block can accept a packed word.
REQ-007 SHALL have port s_vectors, input, N_VEC*VEC_W (155) bits: packed word, vector k at bits [k*VEC_W+VEC_W-1 : k*VEC_W].
REQ-008 SHALL have port m_valid, output, 1 bit: m_data holds a valid vector.
REQ-009 SHALL have port m_ready, input, 1 bit: downstream accepts the vector.
REQ-010 SHALL have port m_data, output, VEC_W bits: current unpacked vector.
REQ-011 SHALL have port m_index, output, $clog2(N_VEC) (3) bits: index k of m_data.
REQ-012 SHALL have port m_last, output, 1 bit: high when m_index == N_VEC-1.
REQ-013 SHALL have port busy, output, 1 bit: high in state SEND.

Function
REQ-014 SHALL implement an FSM with two states: IDLE and SEND.
REQ-015 In IDLE, s_ready SHALL be 1, m_valid 0; on s_valid & s_ready, the word SHALL be captured, index reset to 0, and the FSM SHALL go to SEND.
REQ-016 In SEND, m_valid SHALL be 1 and m_data SHALL equal captured vector m_index, emitted in order 0, 1, ..., N_VEC-1.
REQ-017 A beat SHALL transfer only on m_valid & m_ready; the index SHALL then advance by 1.
REQ-018 While m_valid & !m_ready, m_data, m_index and m_last SHALL hold stable.
REQ-019 In SEND, s_ready SHALL equal m_last & m_ready, so that a new word may be captured in the same cycle as the last beat.
REQ-020 On last-beat transfer with a simultaneous s_valid, the FSM SHALL stay in SEND with index 0 and the new word, giving zero bubble cycles; without s_valid it SHALL return to IDLE.
REQ-021 Latency from the s handshake to first m_valid SHALL be exactly 1 cycle; steady-state throughput SHALL be N_VEC beats per word.
REQ-022 The index counter SHALL never exceed N_VEC-1; wrap-around SHALL occur only via REQ-020.
REQ-023 s_vectors SHALL be ignored when s_ready is 0.

Reset
REQ-024 On rst_n low, the FSM SHALL enter IDLE and outputs SHALL be: s_ready=1 after release, m_valid=0, m_data=0, m_index=0, m_last=0, busy=0.
REQ-025 Reset asserted mid-word SHALL discard remaining beats; no partial beat SHALL appear after release.

Configuration
REQ-026 Macro VEC_UNPACK_XOR_CHECK_EN SHALL control an XOR self-check.
REQ-027 With the macro defined, the block SHALL add outputs acc_xor (VEC_W bits) and acc_valid (1 bit).
REQ-028 With the macro defined, acc_xor SHALL hold the running XOR of transferred beats of the current word, cleared on capture.
REQ-029 With the macro defined, acc_valid SHALL pulse 1 cycle after the last-beat transfer, and acc_xor SHALL then equal the combinational XOR-tree result of that word.
REQ-030 With the macro defined, acc_xor and acc_valid SHALL reset to 0.
REQ-031 Without the macro, these ports and all related logic SHALL be absent.

Structure
REQ-032 A shared package SHALL hold N_VEC, VEC_W, the IDX_W constant, and the FSM state enum {IDLE, SEND}.
REQ-033 The block SHALL have one sub-module, vec_unpack_acc (the XOR accumulator), instantiated only under VEC_UNPACK_XOR_CHECK_EN.

Verification
REQ-034 Single word, m_ready=1 constantly, with s_vectors = {31'h5, 31'h4, 31'h3, 31'h2, 31'h1} -> m_data 1,2,3,4,5 on 5 consecutive cycles starting 1 cycle after the handshake; m_last only on value 5.
REQ-035 Back-to-back words with s_valid held high -> 10 beats with no gap; s_ready high only on cycles where last beat transfers.
REQ-036 m_ready low for 3 cycles at index 2 -> m_data/m_index held at vector 2 for 3 cycles, then the sequence resumes with no beat lost or duplicated.
REQ-037 rst_n asserted at index 3 -> m_valid=0 immediately; after release, s_ready=1 and a new word starts at index 0.
REQ-038 With XOR check enabled, word {31'h7FFFFFFF, 31'h0, 31'h1, 31'h2, 31'h4} -> acc_valid pulse with acc_xor = 31'h7FFFFFF8.

Source files
------------

// File: rtl/vec_unpack_5_31_pkg.sv
// Shared constants and FSM state type for the vec_unpack_5_31 block.
package vec_unpack_5_31_pkg;

  localparam int N_VEC = 5;
  localparam int VEC_W = 31;
  localparam int IDX_W = $clog2(N_VEC);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/vec_unpack_acc.sv
// Running XOR of the beats of one word; pulses acc_valid_o one cycle after
// the last beat of that word has transferred.
module vec_unpack_acc
  import vec_unpack_5_31_pkg::*;
#(
  parameter int VEC_W = vec_unpack_5_31_pkg::VEC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             beat_i,
  input  logic             last_i,
  input  logic [VEC_W-1:0] data_i,
  output logic [VEC_W-1:0] acc_xor_o,
  output logic             acc_valid_o
);

  logic [VEC_W-1:0] acc_q, acc_d;
  logic             fresh_q, fresh_d;
  logic             valid_q, valid_d;

  // Next-state: fold in each beat. When a new word is captured on the same
  // edge as the previous last beat, the finished result must stay visible for
  // the acc_valid cycle, so the clear is deferred via fresh_q to the next beat.
  always_comb begin
    acc_d   = acc_q;
    fresh_d = fresh_q;
    valid_d = beat_i & last_i;
    if (beat_i) begin
      acc_d   = (fresh_q ? '0 : acc_q) ^ data_i;
      fresh_d = last_i;
    end else if (clear_i) begin
      acc_d   = '0;
      fresh_d = 1'b0;
    end
  end

  // State registers with asynchronous reset to an empty accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      fresh_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      fresh_q <= fresh_d;
      valid_q <= valid_d;
    end
  end

  assign acc_xor_o   = acc_q;
  assign acc_valid_o = valid_q;

endmodule

// File: rtl/vec_unpack_5_31.sv
// Unpacks a word of N_VEC vectors into a stream of VEC_W-bit beats.
// Optional XOR self-check enabled by defining VEC_UNPACK_XOR_CHECK_EN.
module vec_unpack_5_31 #(
  parameter  int N_VEC = vec_unpack_5_31_pkg::N_VEC,
  parameter  int VEC_W = vec_unpack_5_31_pkg::VEC_W,
  localparam int IW    = (N_VEC > 1) ? $clog2(N_VEC) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [N_VEC*VEC_W-1:0] s_vectors,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [VEC_W-1:0]       m_data,
  output logic [IW-1:0]          m_index,
  output logic                   m_last,
  output logic                   busy
`ifdef VEC_UNPACK_XOR_CHECK_EN
  ,
  output logic [VEC_W-1:0]       acc_xor,
  output logic                   acc_valid
`endif
);

  import vec_unpack_5_31_pkg::*;

  localparam logic [IW-1:0] LAST_IDX = IW'(N_VEC - 1);

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [N_VEC*VEC_W-1:0] word_q, word_d;
  logic [VEC_W-1:0]       vec_arr [N_VEC];
  logic                   at_last, beat, cap;

  // Unpacked view of the captured word for index selection.
  for (genvar gi = 0; gi < N_VEC; gi++) begin : g_slice
    assign vec_arr[gi] = word_q[gi*VEC_W +: VEC_W];
  end

  assign busy    = (state_q == SEND);
  assign m_valid = busy;
  assign m_index = idx_q;
  assign m_data  = vec_arr[idx_q];
  assign at_last = (idx_q == LAST_IDX);
  assign m_last  = busy & at_last;
  assign beat    = m_valid & m_ready;
  // In SEND a new word is only taken alongside the last beat (zero bubble).
  assign s_ready = ~busy | (m_last & m_ready);
  assign cap     = s_valid & s_ready;

  // Next-state: capture wins (it either starts from IDLE or coincides with the
  // last beat); otherwise a transferred beat advances or finishes the word.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    if (cap) begin
      word_d  = s_vectors;
      idx_d   = '0;
      state_d = SEND;
    end else if (beat) begin
      if (at_last) begin
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  // FSM, index and word registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

`ifdef VEC_UNPACK_XOR_CHECK_EN
  vec_unpack_acc #(
    .VEC_W(VEC_W)
  ) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (cap & ~busy),
    .beat_i     (beat),
    .last_i     (at_last),
    .data_i     (m_data),
    .acc_xor_o  (acc_xor),
    .acc_valid_o(acc_valid)
  );
`endif

endmodule

// File: tb/tb_vec_unpack_5_31.sv
// Bench for vec_unpack_5_31: expected beats are queued when a word is driven
// and checked by a monitor as they transfer; tasks check timing/handshakes.
module tb_vec_unpack_5_31;

  localparam int N  = 5;
  localparam int W  = 31;
  localparam int IW = 3;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [IW-1:0] i;
    logic          l;
  } beat_t;

  logic           clk;
  logic           rst_n;
  logic           s_valid;
  logic           s_ready;
  logic [N*W-1:0] s_vectors;
  logic           m_valid;
  logic           m_ready;
  logic [W-1:0]   m_data;
  logic [IW-1:0]  m_index;
  logic           m_last;
  logic           busy;
`ifdef VEC_UNPACK_XOR_CHECK_EN
  logic [W-1:0]   acc_xor;
  logic           acc_valid;
`endif

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  vec_unpack_5_31 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_vectors(s_vectors),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_index  (m_index),
    .m_last   (m_last),
    .busy     (busy)
`ifdef VEC_UNPACK_XOR_CHECK_EN
    ,
    .acc_xor  (acc_xor),
    .acc_valid(acc_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every transferring beat must match the queue head.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      beat_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat: got data=%h idx=%0d, expected no beat", m_data, m_index);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e.d || m_index !== e.i || m_last !== e.l) begin
          bad++;
          $display("FAIL beat: got data=%h idx=%0d last=%b, expected data=%h idx=%0d last=%b",
                   m_data, m_index, m_last, e.d, e.i, e.l);
        end else begin
          $display("beat ok: data=%h idx=%0d last=%b", m_data, m_index, m_last);
        end
      end
    end
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic push_word(input logic [N*W-1:0] w);
    for (int k = 0; k < N; k++) begin
      beat_t b;
      b.d = w[k*W +: W];
      b.i = IW'(k);
      b.l = (k == N - 1);
      exp_q.push_back(b);
    end
  endtask

  function automatic logic [N*W-1:0] mk_word(input logic [W-1:0] v0, input logic [W-1:0] v1,
                                             input logic [W-1:0] v2, input logic [W-1:0] v3,
                                             input logic [W-1:0] v4);
    return {v4, v3, v2, v1, v0};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_vectors = '0;
    repeat (2) @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || m_data !== '0 || m_index !== '0 || m_last !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b d=%h i=%0d l=%b b=%b, expected all 0",
               m_valid, m_data, m_index, m_last, busy);
    end else $display("reset outputs ok");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got s_ready=%b m_valid=%b, expected 1/0", s_ready, m_valid);
    end else $display("reset release ok");
  endtask

  task automatic test_single();
    logic [N*W-1:0] w;
    w = mk_word(31'h1, 31'h2, 31'h3, 31'h4, 31'h5);
    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b1; s_vectors = w; push_word(w);
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: got s_ready=%b m_valid=%b, expected 1/0", s_ready, m_valid);
    end
    @(posedge clk); #1 s_valid = 1'b0; s_vectors = '1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      total++;
      if (m_valid !== 1'b1 || busy !== 1'b1) begin
        bad++;
        $display("FAIL single_stream: cycle %0d got m_valid=%b busy=%b, expected 1/1", i, m_valid, busy);
      end
    end
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL single_end: got m_valid=%b busy=%b left=%0d, expected 0/0/0",
               m_valid, busy, exp_q.size());
    end else $display("single word ok");
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] wa, wb;
    logic           exp_rdy;
    wa = mk_word(31'h11, 31'h22, 31'h33, 31'h44, 31'h55);
    wb = mk_word(31'h7A5A5A5A, 31'h05A5A5A5, 31'h0, 31'h7FFFFFFF, 31'h1234567);
    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b1; s_vectors = wa; push_word(wa);
    @(posedge clk); #1;
    s_vectors = wb; push_word(wb);
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      exp_rdy = (i == N - 1) || (i == 2 * N - 1);
      total++;
      if (m_valid !== 1'b1 || s_ready !== exp_rdy) begin
        bad++;
        $display("FAIL b2b: cycle %0d got m_valid=%b s_ready=%b, expected 1/%b", i, m_valid, s_ready, exp_rdy);
      end
      @(posedge clk); #1;
      if (i == N - 1) s_valid = 1'b0;
    end
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_end: got m_valid=%b left=%0d, expected 0/0", m_valid, exp_q.size());
    end else $display("back to back ok");
  endtask

  task automatic test_stall();
    logic [N*W-1:0] w;
    w = mk_word(31'h0A, 31'h0B, 31'h0C, 31'h0D, 31'h0E);
    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b1; s_vectors = w; push_word(w);
    @(posedge clk); #1 s_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (m_valid !== 1'b1 || m_index !== 3'd2 || m_data !== 31'h0C || m_last !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold: cycle %0d got v=%b i=%0d d=%h l=%b, expected 1/2/0c/0",
                 k, m_valid, m_index, m_data, m_last);
      end
      @(posedge clk);
    end
    #1 m_ready = 1'b1;
    for (int c = 0; c < 20 && m_valid; c++) @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL stall_resume: got m_valid=%b left=%0d, expected 0/0", m_valid, exp_q.size());
    end else $display("stall ok");
  endtask

  task automatic test_reset_mid();
    logic [N*W-1:0] w, w2;
    w  = mk_word(31'h101, 31'h202, 31'h303, 31'h404, 31'h505);
    w2 = mk_word(31'h6001, 31'h6002, 31'h6003, 31'h6004, 31'h6005);
    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b1; s_vectors = w; push_word(w);
    @(posedge clk); #1 s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (m_index !== 3'd3) begin
      bad++;
      $display("FAIL midrst_setup: got m_index=%0d, expected 3", m_index);
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || m_index !== '0) begin
      bad++;
      $display("FAIL midrst_async: got v=%b b=%b i=%0d, expected 0/0/0", m_valid, busy, m_index);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_release: got s_ready=%b m_valid=%b, expected 1/0", s_ready, m_valid);
    end
    @(posedge clk); #1;
    s_valid = 1'b1; s_vectors = w2; push_word(w2);
    @(posedge clk); #1 s_valid = 1'b0;
    @(negedge clk);
    total++;
    if (m_valid !== 1'b1 || m_index !== '0 || m_data !== 31'h6001) begin
      bad++;
      $display("FAIL midrst_restart: got v=%b i=%0d d=%h, expected 1/0/6001", m_valid, m_index, m_data);
    end
    for (int c = 0; c < 20 && m_valid; c++) @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL midrst_end: got m_valid=%b left=%0d, expected 0/0", m_valid, exp_q.size());
    end else $display("mid-word reset ok");
  endtask

`ifdef VEC_UNPACK_XOR_CHECK_EN
  task automatic test_xor_check();
    logic [N*W-1:0] w;
    logic [W-1:0]   fold;
    bit             seen;
    w = mk_word(31'h4, 31'h2, 31'h1, 31'h0, 31'h7FFFFFFF);
    fold = '0;
    for (int k = 0; k < N; k++) fold ^= w[k*W +: W];
    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b1; s_vectors = w; push_word(w);
    @(posedge clk); #1 s_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (acc_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen || acc_xor !== fold || acc_xor !== 31'h7FFFFFF8) begin
      bad++;
      $display("FAIL xor_check: got seen=%b acc_xor=%h, expected 1/%h", seen, acc_xor, fold);
    end else $display("xor check ok: %h", acc_xor);
    @(negedge clk);
    total++;
    if (acc_valid !== 1'b0) begin
      bad++;
      $display("FAIL xor_pulse: got acc_valid=%b, expected 0", acc_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef VEC_UNPACK_XOR_CHECK_EN
    test_xor_check();
`endif
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending beats, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
